// File: rtl/prs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prs_pkg
// Description : Shared definitions for the pulse-counter bank: command
//               opcodes, the 2-bit FSM state encoding and the frame-width
//               helper.
// Revision    : 1.0 - initial release
// ============================================================================
package prs_pkg;

  // Command opcodes, carried in i_rx_buff[NUM_CH+1:NUM_CH]
  localparam logic [1:0] C_OP_NOP     = 2'b00;
  localparam logic [1:0] C_OP_SET_EN  = 2'b01;
  localparam logic [1:0] C_OP_CLEAR   = 2'b10;
  localparam logic [1:0] C_OP_SET_SAT = 2'b11;

  // Frame-controller states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_SNAP    = 2'b01,
    ST_PRESENT = 2'b10,
    ST_BUSY    = 2'b11
  } state_t;

  // Snapshot frame width: one count per channel plus one ovf bit per channel
  function automatic int frame_w(input int num_ch, input int cnt_w);
    return num_ch * cnt_w + num_ch;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cnt_channel.sv
`default_nettype none
// ============================================================================
// Module      : cnt_channel
// Description : One counter channel: 2-flop synchroniser, rising-edge
//               detector, CNT_W-bit counter with wrap/saturate behaviour,
//               sticky overflow flag and the snapshot shadow register.
// Ports       : i_clk, i_rst_n   - clock, async active-low reset
//               i_pulse          - asynchronous pulse input
//               i_en / i_sat     - count enable / saturate-mode select
//               i_snap           - copy live state into shadow, restart live
//               i_clear          - zero live counter and flag (wins over snap)
//               o_ovf            - live overflow flag
//               o_shadow_cnt/ovf - frozen snapshot values
// Revision    : 1.0 - initial release
// ============================================================================
module cnt_channel #(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_pulse,
  input  logic             i_en,
  input  logic             i_sat,
  input  logic             i_snap,
  input  logic             i_clear,
  output logic             o_ovf,
  output logic [CNT_W-1:0] o_shadow_cnt,
  output logic             o_shadow_ovf
);

  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

  logic [1:0]       r_sync;
  logic             r_prev;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic [CNT_W-1:0] r_shadow_cnt;
  logic             r_shadow_ovf;
  logic             w_inc;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_pulse};
      r_prev <= r_sync[1];
    end
  end

  assign w_inc = r_sync[1] & ~r_prev & i_en;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (i_clear) begin
      // Clear beats both the snapshot restart and a coincident edge
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (i_snap) begin
      // Live restarts from zero; an edge in this cycle is kept as the first count
      r_cnt <= w_inc ? CNT_W'(1) : '0;
      r_ovf <= 1'b0;
    end else if (w_inc) begin
      if (r_cnt == C_CNT_MAX) begin
        r_ovf <= 1'b1;
        r_cnt <= i_sat ? C_CNT_MAX : '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shadow_cnt <= '0;
      r_shadow_ovf <= 1'b0;
    end else if (i_snap) begin
      r_shadow_cnt <= r_cnt;
      r_shadow_ovf <= r_ovf;
    end
  end

  assign o_ovf        = r_ovf;
  assign o_shadow_cnt = r_shadow_cnt;
  assign o_shadow_ovf = r_shadow_ovf;

endmodule
`default_nettype wire

// File: rtl/cnt_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cnt_bank_ctrl
// Description : Pulse-counter bank with atomic snapshot frame for an SPI
//               slave. Holds the frame FSM, command decode, enable and
//               saturate masks, PRESENT timeout and the overflow summary.
// Ports       : i_clk, i_rst_n    - clock, async active-low reset
//               i_cnt_channels    - asynchronous pulse inputs
//               i_spi_tx_req      - request a new frame (honoured in IDLE)
//               i_spi_busy        - SPI transfer in progress
//               o_tx_buff         - {shadow ovf flags, shadow counts}
//               o_tx_valid        - frame ready for loading
//               i_rx_buff/valid   - {opcode, mask} command and strobe
//               o_cnt_enable      - current enable mask
//               o_ovf_any         - OR of live overflow flags (registered)
// Revision    : 1.0 - initial release
// ============================================================================
module cnt_bank_ctrl
  import prs_pkg::*;
#(
  parameter int NUM_CH  = 16,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic                                i_clk,
  input  logic                                i_rst_n,
  input  logic [NUM_CH-1:0]                   i_cnt_channels,
  input  logic                                i_spi_tx_req,
  input  logic                                i_spi_busy,
  output logic [frame_w(NUM_CH, CNT_W)-1:0]   o_tx_buff,
  output logic                                o_tx_valid,
  input  logic [NUM_CH+1:0]                   i_rx_buff,
  input  logic                                i_rx_valid,
  output logic [NUM_CH-1:0]                   o_cnt_enable,
  output logic                                o_ovf_any
);

  state_t                       r_state;
  state_t                       w_next_state;
  logic                         w_snap;
  logic [TO_W-1:0]              r_to_cnt;
  logic                         w_to_done;
  logic                         r_tx_valid;
  logic                         r_ovf_any;
  logic [NUM_CH-1:0]            r_en;
  logic [NUM_CH-1:0]            r_sat;
  logic [1:0]                   w_op;
  logic [NUM_CH-1:0]            w_mask;
  logic                         w_set_en;
  logic                         w_set_sat;
  logic                         w_clear_cmd;
  logic [NUM_CH-1:0]            w_clear;
  logic [NUM_CH-1:0]            w_ovf_live;
  logic [NUM_CH-1:0][CNT_W-1:0] w_shadow_cnt;
  logic [NUM_CH-1:0]            w_shadow_ovf;

  // ---------------- Command decode ----------------
  assign w_op   = i_rx_buff[NUM_CH+1:NUM_CH];
  assign w_mask = i_rx_buff[NUM_CH-1:0];

  always_comb begin
    w_set_en    = 1'b0;
    w_set_sat   = 1'b0;
    w_clear_cmd = 1'b0;
    if (i_rx_valid) begin
      case (w_op)
        C_OP_NOP:     ;
        C_OP_SET_EN:  w_set_en    = 1'b1;
        C_OP_CLEAR:   w_clear_cmd = 1'b1;
        C_OP_SET_SAT: w_set_sat   = 1'b1;
        default:      ;
      endcase
    end
  end

  assign w_clear = w_clear_cmd ? w_mask : '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_en  <= '0;
      r_sat <= '0;
    end else begin
      if (w_set_en)  r_en  <= w_mask;
      if (w_set_sat) r_sat <= w_mask;
    end
  end

  // ---------------- Frame FSM ----------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  assign w_to_done = (r_to_cnt == TO_W'(TIMEOUT - 1));

  always_comb begin
    w_next_state = r_state;
    w_snap       = 1'b0;
    case (r_state)
      ST_IDLE:    if (i_spi_tx_req) w_next_state = ST_SNAP;
      ST_SNAP: begin
        w_snap       = 1'b1;
        w_next_state = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (i_spi_busy)     w_next_state = ST_BUSY;
        else if (w_to_done) w_next_state = ST_IDLE;
      end
      ST_BUSY:    if (!i_spi_busy) w_next_state = ST_IDLE;
      default:    w_next_state = ST_IDLE;
    endcase
  end

  // Counts PRESENT cycles without busy; restarts on every PRESENT entry
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_to_cnt <= '0;
    end else if (r_state != ST_PRESENT) begin
      r_to_cnt <= '0;
    end else if (!w_to_done) begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tx_valid <= 1'b0;
      r_ovf_any  <= 1'b0;
    end else begin
      r_tx_valid <= (w_next_state == ST_PRESENT);
      r_ovf_any  <= |w_ovf_live;
    end
  end

  // ---------------- Channels ----------------
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    cnt_channel #(
      .CNT_W (CNT_W)
    ) u_ch (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_pulse      (i_cnt_channels[gi]),
      .i_en         (r_en[gi]),
      .i_sat        (r_sat[gi]),
      .i_snap       (w_snap),
      .i_clear      (w_clear[gi]),
      .o_ovf        (w_ovf_live[gi]),
      .o_shadow_cnt (w_shadow_cnt[gi]),
      .o_shadow_ovf (w_shadow_ovf[gi])
    );
    assign o_tx_buff[CNT_W*gi +: CNT_W] = w_shadow_cnt[gi];
  end

  assign o_tx_buff[NUM_CH*CNT_W +: NUM_CH] = w_shadow_ovf;
  assign o_tx_valid   = r_tx_valid;
  assign o_cnt_enable = r_en;
  assign o_ovf_any    = r_ovf_any;

endmodule
`default_nettype wire

// File: tb/tb_cnt_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cnt_bank_ctrl
// Description : Self-checking bench for cnt_bank_ctrl with a behavioural
//               channel model and an expected-frame queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cnt_bank_ctrl;

  localparam int NUM_CH = 16;
  localparam int CNT_W  = 8;
  localparam int FW     = NUM_CH * CNT_W + NUM_CH;

  logic              clk;
  logic              rst_n;
  logic [NUM_CH-1:0] chans;
  logic              tx_req;
  logic              busy;
  logic [FW-1:0]     tx_buff;
  logic              tx_valid;
  logic [NUM_CH+1:0] rx_buff;
  logic              rx_valid;
  logic [NUM_CH-1:0] cnt_enable;
  logic              ovf_any;

  cnt_bank_ctrl #(
    .NUM_CH  (NUM_CH),
    .CNT_W   (CNT_W),
    .TIMEOUT (4),
    .TO_W    (3)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_cnt_channels (chans),
    .i_spi_tx_req   (tx_req),
    .i_spi_busy     (busy),
    .o_tx_buff      (tx_buff),
    .o_tx_valid     (tx_valid),
    .i_rx_buff      (rx_buff),
    .i_rx_valid     (rx_valid),
    .o_cnt_enable   (cnt_enable),
    .o_ovf_any      (ovf_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model of the live channel state
  logic [CNT_W-1:0]  m_cnt [NUM_CH];
  logic              m_ovf [NUM_CH];
  logic [NUM_CH-1:0] m_en;
  logic [NUM_CH-1:0] m_sat;
  logic [FW-1:0]     exp_q [$];
  logic [FW-1:0]     last_frame;

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_cnt[i] = '0;
      m_ovf[i] = 1'b0;
    end
    m_en  = '0;
    m_sat = '0;
    exp_q.delete();
  endtask

  task automatic model_edge(input int i);
    if (m_en[i]) begin
      if (m_cnt[i] == 8'hFF) begin
        m_ovf[i] = 1'b1;
        m_cnt[i] = m_sat[i] ? 8'hFF : 8'h00;
      end else begin
        m_cnt[i] = m_cnt[i] + 8'd1;
      end
    end
  endtask

  // Expected frame from the current model; the snapshot then restarts live state
  task automatic push_frame();
    logic [FW-1:0] f;
    f = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      f[CNT_W*i +: CNT_W]  = m_cnt[i];
      f[NUM_CH*CNT_W + i]  = m_ovf[i];
      m_cnt[i] = '0;
      m_ovf[i] = 1'b0;
    end
    exp_q.push_back(f);
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [NUM_CH-1:0] mask);
    @(negedge clk);
    rx_buff  = {op, mask};
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    case (op)
      2'b01: m_en  = mask;
      2'b11: m_sat = mask;
      2'b10: for (int i = 0; i < NUM_CH; i++) if (mask[i]) begin
               m_cnt[i] = '0;
               m_ovf[i] = 1'b0;
             end
      default: ;
    endcase
  endtask

  task automatic pulses(input logic [NUM_CH-1:0] mask, input int n);
    for (int p = 0; p < n; p++) begin
      @(negedge clk);
      chans = mask;
      @(negedge clk);
      @(negedge clk);
      chans = '0;
      @(negedge clk);
      for (int i = 0; i < NUM_CH; i++) if (mask[i]) model_edge(i);
    end
    repeat (3) @(negedge clk);
  endtask

  // Request a frame; optionally raise an edge and/or CLEAR during the SNAP cycle.
  // Returns at the first PRESENT negedge after popping and checking the frame.
  task automatic do_request(input string name, input logic [NUM_CH-1:0] snap_pulse,
                            input logic [NUM_CH-1:0] snap_clear);
    logic [FW-1:0] exp_f;
    int            waited;
    @(negedge clk);
    if (snap_pulse != '0) begin
      chans = snap_pulse;
      @(negedge clk);
    end
    tx_req = 1'b1;
    push_frame();
    @(negedge clk);
    tx_req = 1'b0;
    if (snap_clear != '0) begin
      rx_buff  = {2'b10, snap_clear};
      rx_valid = 1'b1;
    end
    n_checks++;
    if (tx_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL %s snap_valid: got %b want 0", name, tx_valid);
    end
    @(negedge clk);
    rx_valid = 1'b0;
    chans    = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (snap_pulse[i] && !snap_clear[i]) model_edge(i);
    n_checks++;
    if (tx_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL %s valid_latency: got %b want 1", name, tx_valid);
    end
    waited = 0;
    while (tx_valid !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    exp_f = exp_q.pop_front();
    n_checks++;
    if (waited >= 20) begin
      n_errors++;
      $display("FAIL %s frame_timeout: tx_valid never rose", name);
    end else if (tx_buff !== exp_f) begin
      n_errors++;
      $display("FAIL %s frame: got %h want %h", name, tx_buff, exp_f);
    end
    last_frame = exp_f;
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while (tx_valid !== 1'b0 && w < 20) begin
      @(negedge clk);
      w++;
    end
    n_checks++;
    if (w >= 20) begin
      n_errors++;
      $display("FAIL wait_idle: tx_valid stuck at %b", tx_valid);
    end
    repeat (2) @(negedge clk);
  endtask

  function automatic logic [FW-1:0] frame1(input int ch, input logic [7:0] v, input logic ovf);
    logic [FW-1:0] f;
    f = '0;
    f[CNT_W*ch +: CNT_W] = v;
    f[NUM_CH*CNT_W + ch] = ovf;
    return f;
  endfunction

  // ---------------- Scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({tx_valid, ovf_any, cnt_enable, tx_buff} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: valid=%b ovf_any=%b en=%h buff=%h want all 0",
               tx_valid, ovf_any, cnt_enable, tx_buff);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_disabled();
    pulses('1, 3);
    do_request("disabled", '0, '0);
    wait_idle();
  endtask

  task automatic test_basic_count();
    send_cmd(2'b01, 16'h0003);
    n_checks++;
    if (cnt_enable !== 16'h0003) begin
      n_errors++;
      $display("FAIL set_en: got %h want 0003", cnt_enable);
    end
    pulses(16'h0007, 2);
    pulses(16'h0003, 1);
    pulses(16'h0001, 2);
    do_request("basic", '0, '0);
    n_checks++;
    if (last_frame !== (frame1(0, 8'd5, 1'b0) | frame1(1, 8'd3, 1'b0))) begin
      n_errors++;
      $display("FAIL basic_model: got %h", last_frame);
    end
    wait_idle();
    do_request("empty_second", '0, '0);
    wait_idle();
  endtask

  task automatic test_overflow();
    pulses(16'h0001, 257);
    n_checks++;
    if (ovf_any !== 1'b1) begin
      n_errors++;
      $display("FAIL ovf_any_set: got %b want 1", ovf_any);
    end
    do_request("wrap", '0, '0);
    repeat (2) @(negedge clk);
    n_checks++;
    if (ovf_any !== 1'b0) begin
      n_errors++;
      $display("FAIL ovf_any_after_snap: got %b want 0", ovf_any);
    end
    wait_idle();
    send_cmd(2'b11, 16'h0001);
    pulses(16'h0001, 300);
    do_request("saturate", '0, '0);
    n_checks++;
    if (tx_buff !== frame1(0, 8'hFF, 1'b1)) begin
      n_errors++;
      $display("FAIL saturate_abs: got %h want %h", tx_buff, frame1(0, 8'hFF, 1'b1));
    end
    wait_idle();
    send_cmd(2'b11, 16'h0000);
  endtask

  task automatic test_snap_edge();
    pulses(16'h0001, 2);
    do_request("edge_in_snap", 16'h0003, '0);
    wait_idle();
    do_request("edge_next", '0, '0);
    wait_idle();
    pulses(16'h0003, 4);
    do_request("clear_in_snap", 16'h0003, 16'h0001);
    wait_idle();
    do_request("clear_next", '0, '0);
    n_checks++;
    if (tx_buff !== frame1(1, 8'd1, 1'b0)) begin
      n_errors++;
      $display("FAIL clear_next_abs: got %h want %h", tx_buff, frame1(1, 8'd1, 1'b0));
    end
    wait_idle();
  endtask

  task automatic test_timeout_busy();
    int hi;
    pulses(16'h0001, 1);
    do_request("timeout", '0, '0);
    hi = 0;
    while (tx_valid === 1'b1 && hi < 20) begin
      hi++;
      @(negedge clk);
    end
    n_checks++;
    if (hi != 4) begin
      n_errors++;
      $display("FAIL timeout_len: got %0d cycles want 4", hi);
    end
    do_request("busy", '0, '0);
    busy = 1'b1;
    @(negedge clk);
    n_checks++;
    if (tx_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL busy_valid: got %b want 0", tx_valid);
    end
    tx_req = 1'b1;
    @(negedge clk);
    tx_req = 1'b0;
    pulses(16'h0001, 2);
    n_checks++;
    if (tx_valid !== 1'b0 || tx_buff !== last_frame) begin
      n_errors++;
      $display("FAIL busy_hold: valid=%b buff=%h want 0 / %h", tx_valid, tx_buff, last_frame);
    end
    busy = 1'b0;
    repeat (2) @(negedge clk);
    do_request("after_busy", '0, '0);
    wait_idle();
  endtask

  task automatic test_async_reset();
    send_cmd(2'b01, 16'h0001);
    pulses(16'h0001, 3);
    do_request("pre_reset", '0, '0);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({tx_valid, tx_buff, cnt_enable, ovf_any} !== '0) begin
      n_errors++;
      $display("FAIL async_reset: valid=%b buff=%h en=%h want 0", tx_valid, tx_buff, cnt_enable);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    pulses(16'h0001, 3);
    do_request("post_reset", '0, '0);
    wait_idle();
    send_cmd(2'b01, 16'h0001);
    pulses(16'h0001, 2);
    do_request("post_reset_en", '0, '0);
    wait_idle();
  endtask

  initial begin
    chans    = '0;
    tx_req   = 1'b0;
    busy     = 1'b0;
    rx_buff  = '0;
    rx_valid = 1'b0;
    rst_n    = 1'b0;
    model_reset();
    test_reset();
    test_disabled();
    test_basic_count();
    test_overflow();
    test_snap_edge();
    test_timeout_busy();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cnt_bank_ctrl.md
# cnt_bank_ctrl

Parametrised pulse-counter bank with atomic snapshot, per-channel wrap/saturate mode and sticky overflow flags. Sits between the channel input pins and `spi_slave`. It presents a frozen counter frame on the TX side and decodes opcode-tagged commands from the RX side. Counting continues without loss while a frame is being shifted out.

## Interface
- `NUM_CH`, 16: number of counter channels.
- `CNT_W`, 8: counter width, in bits.
- `TIMEOUT`, 255: cycles allowed in PRESENT without `i_spi_busy` before the frame is abandoned. Must be ≥1.
- `TO_W`, 8: timeout counter width. Must satisfy 2^TO_W > TIMEOUT.

Ports:
- `i_clk`, in, 1: the only clock.
- `i_rst_n`, in, 1: asynchronous, active-low reset.
- `i_cnt_channels`, in, NUM_CH: asynchronous pulse inputs.
- `i_spi_tx_req`, in, 1: one-cycle request for a new frame.
- `i_spi_busy`, in, 1: high while the SPI transfer is in progress.
- `o_tx_buff`, out, NUM_CH*CNT_W+NUM_CH: snapshot frame.
- `o_tx_valid`, out, 1: frame ready for loading.
- `i_rx_buff`, in, NUM_CH+2: command word.
- `i_rx_valid`, in, 1: one-cycle command strobe.
- `o_cnt_enable`, out, NUM_CH: current enable mask.
- `o_ovf_any`, out, 1: OR of all live overflow flags.

## Operation
- Per channel, the input path is a 2-flop synchroniser, then a rising-edge detector, then the counter.
  - The counter increments only when its `o_cnt_enable` bit is 1.
  - Input high time and low time must each be ≥2 `i_clk` periods.
- Counter at max (2^CNT_W−1) receiving an edge:
  - Wrap mode: counter goes to 0 and the channel's ovf flag is set.
  - Saturate mode: counter holds at max and the ovf flag is set.
- The ovf flag is sticky until that channel is snapshotted or cleared.
- Command word: `i_rx_buff[NUM_CH+1:NUM_CH]` is the opcode and `[NUM_CH-1:0]` is the mask. Commands are accepted on any cycle in which `i_rx_valid`=1, in any state.
  - 00 NOP.
  - 01 SET_EN: enable mask ← mask.
  - 10 CLEAR: live counter and ovf flag ← 0 for every channel whose mask bit is 1.
  - 11 SET_SAT: saturate-mode mask ← mask. A 0 bit selects wrap mode.
- Frame layout:
  - `o_tx_buff[CNT_W*i +: CNT_W]` = shadow count of channel i.
  - `o_tx_buff[NUM_CH*CNT_W +: NUM_CH]` = shadow ovf flags.
- FSM states and transitions:
  - IDLE: on `i_spi_tx_req` go to SNAP.
  - SNAP, exactly 1 cycle: shadow ← live counters and flags; live counters and flags ← 0. An edge detected in this same cycle loads the live counter with 1, so no count is lost. Then go to PRESENT.
  - PRESENT: `o_tx_valid`=1. On `i_spi_busy`=1 go to BUSY. After TIMEOUT cycles without busy, go to IDLE; the shadow frame stays in place.
  - BUSY: `o_tx_valid`=0. On `i_spi_busy`=0 go to IDLE.
  - Unused encodings go to IDLE.
- CLEAR in the SNAP cycle: the shadow captures the pre-clear value and the live counter ends at 0. A coincident edge on that channel is dropped, because CLEAR wins.
- SET_EN in the SNAP cycle: the new mask takes effect from the next cycle.
- `i_spi_tx_req` outside IDLE is ignored.

## Timing
- Reset values:
  - `o_tx_buff`, `o_tx_valid`, `o_cnt_enable`, `o_ovf_any` = 0.
  - Saturate mask = 0 (all channels in wrap mode).
  - Live counters, shadow registers and synchronisers = 0.
  - State = IDLE.
- Reset asserted mid-operation returns all of the above to these values asynchronously.
- Edge latency: the input is first sampled high at clock edge k, and the live counter shows the increment after edge k+2.
- Request latency:
  - `i_spi_tx_req` high at edge n moves the FSM to SNAP at n.
  - `o_tx_valid` is registered and is 1 after edge n+1.
  - `o_tx_buff` is stable from the SNAP cycle onward and changes only in SNAP.
- Command latency: `i_rx_valid` at edge m takes effect after edge m; `o_cnt_enable` updates at m.
- `o_ovf_any` is registered, with 1-cycle latency after the flag update.

## Structure
- Shared package `prs_pkg` holds:
  - the opcode constants (NOP/SET_EN/CLEAR/SET_SAT);
  - the 2-bit FSM state encoding;
  - the frame-width constant expression.
- Sub-module `cnt_channel`, one per channel, generated:
  - synchroniser, edge detect, CNT_W counter, wrap/sat logic, ovf flag, shadow register;
  - snap and clear inputs.
- The FSM, command decode and timeout counter stay in `cnt_bank_ctrl`.

## Test plan
- Reset → all outputs 0. Pulses on all channels with enable=0 → snapshot reads all counts 0 and all ovf 0.
- SET_EN 0x0003; 5 pulses on ch0, 3 on ch1, 2 on ch2; request → frame shows ch0=5, ch1=3, ch2=0, ovf=0, and `o_tx_valid` is 1 one cycle after the request. A second request with no new pulses → all counts 0.
- CNT_W=8, ch0 in wrap mode, 257 pulses → ch0=1, ovf[0]=1, `o_ovf_any`=1. SET_SAT 0x0001, 300 pulses → ch0=255, ovf[0]=1.
- Edge detected in the SNAP cycle → not in the current frame; the next frame shows 1. CLEAR ch0 in the SNAP cycle → shadow keeps the old value and the next frame shows 0.
- TIMEOUT=4: request with busy held low → `o_tx_valid` drops after 4 cycles and the FSM is in IDLE. A following request plus a busy pulse goes PRESENT→BUSY→IDLE.
- `i_rst_n` low during PRESENT → `o_tx_valid`, `o_tx_buff` and `o_cnt_enable` go to 0 immediately. After release, pulses are not counted until a SET_EN command is received.
